demux_seq: RTL and testbench
============================

# demux_seq

Sequencing controller for the 1-to-8 single-bit demux (`din`, 3-bit `sel`, outputs `dout1`..`dout8`). It accepts one data bit plus an 8-bit destination mask per transfer, then steps `sel` through every destination in the mask, holding each for a programmable dwell. Output is a strobe-qualified bit stream. It sits directly in front of the demux: `sel_o` and `bit_o` drive the demux `sel` and `din` inputs, and `en_o` tells downstream which cycles are valid.

## Interface
- `DWELL`, 2: cycles each destination is held; legal range is 1 or more.
- `GAP`, 1: idle cycles after a transfer before the next accept; legal range is 0 or more.
- `clk` input 1: single clock; all state is rising-edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: transfer offered.
- `in_ready` output 1: block can accept a transfer.
- `in_data` input 1: bit to deliver.
- `in_mask` input 8: destination mask; bit k selects `dout(k+1)`.
- `sel_o` output 3: drives demux `sel`.
- `bit_o` output 1: drives demux `din`.
- `en_o` output 1: high on every cycle a destination is being driven.
- `busy` output 1: high whenever not in IDLE.
- `word_done` output 1: one-cycle pulse when a transfer completes.

## Operation
- FSM has three states: IDLE, ISSUE, GAP.
- `in_ready` is high only in IDLE.
- An accept happens on a rising edge with `in_valid && in_ready`. On accept, `in_data` and `in_mask` are latched into `pend` (8-bit) and the data register.
- IDLE to ISSUE: on accept with a nonzero mask.
- IDLE to GAP (or to IDLE when GAP=0): on accept with a zero mask. `word_done` pulses on the next cycle and no `en_o` is issued.
- ISSUE:
  - Current channel = first set bit of `pend`, searching ascending modulo 8 from `ptr`.
  - `sel_o` = channel, `bit_o` = latched data, `en_o` = 1 for exactly DWELL cycles.
  - At the end of the dwell, that bit is cleared in `pend`.
  - When `pend` becomes 0: go to GAP (or IDLE when GAP=0) and pulse `word_done` in that first post-beat cycle.
- GAP: count GAP cycles with `en_o` = 0, then return to IDLE.
- `ptr`: fixed at 0 unless the macro below is enabled.
- In IDLE and GAP: `en_o` = 0, and `sel_o`/`bit_o` hold their last values. Downstream must qualify on `en_o`.
- `in_valid` held while `busy` is high: no accept and no side effect. The offer is taken on the first IDLE edge.
- Dwell counter width is $clog2(DWELL+1). Gap counter width is $clog2(GAP+1), minimum 1 bit.

## Timing
- Reset values: `sel_o`=0, `bit_o`=0, `en_o`=0, `busy`=0, `word_done`=0, `ptr`=0, `pend`=0, state=IDLE, so `in_ready`=1.
- `rst` asserted mid-transfer: all outputs take their reset values immediately (asynchronously) and the pending beats are discarded.
- All outputs except `in_ready` are registered. `in_ready` is decoded from the state register, not from inputs.
- Accept at edge 0: first `en_o` cycle is cycle 1.
- Transfer length in cycles: N·DWELL issue + 1 `word_done` cycle (which is also the first GAP cycle when GAP≥1) + remaining GAP cycles. `in_ready` rises at cycle N·DWELL + GAP + 1, or N·DWELL + 1 when GAP=0.
- Channel changes are glitch-free: `sel_o` updates only on the edge that starts a new beat.

## Configuration
- `DEMUX_SEQ_RR_EN` defined: after each transfer with a nonzero mask, `ptr` = (last served channel + 1) mod 8. This rotates start priority so that, in aggregate, low-numbered outputs are not always served first.
- `DEMUX_SEQ_RR_EN` undefined: `ptr` is tied to 0 and service order is always ascending from channel 0. No `ptr` register is synthesized.

## Structure
- Shared package `demux_pkg`:
  - `NCH`=8.
  - `SEL_W`=3.
  - FSM state typedef (IDLE/ISSUE/GAP).
- Sub-module `demux_next_ch`: combinational rotating priority encoder. Inputs are the 8-bit mask and the 3-bit start. Outputs are the 3-bit channel and `found`. It is instantiated once in `demux_seq`.

## Test plan
- Reset: hold `rst` 3 cycles, then release. Expect all outputs 0 and `in_ready`=1; no `en_o` for 10 idle cycles.
- DWELL=2, GAP=1, mask 8'b0000_0101, data 1, accept at cycle 0:
  - cycles 1–2: `sel_o`=0, `en_o`=1.
  - cycles 3–4: `sel_o`=2, `en_o`=1.
  - cycle 5: `word_done`=1, `en_o`=0.
  - cycle 6: `in_ready`=1.
- Mask 8'h00: `word_done` at cycle 1 and `en_o` never high. Mask 8'hFF: `sel_o` steps 0..7, with 16 consecutive `en_o` cycles.
- `DEMUX_SEQ_RR_EN` defined, two transfers:
  - mask 8'b0000_0110 serves 1 then 2.
  - Next transfer, mask 8'b0000_1001, serves 3 then 0 (wrap).
  - With the macro undefined, the second transfer serves 0 then 3.
- Hold `in_valid`=1 continuously with 3 transfers queued by the bench. Each accept happens only when `in_ready`=1, with no dropped or duplicated `word_done`.
- Assert `rst` in cycle 3 of the mask 8'b0000_0101 transfer:
  - `en_o` drops within the same cycle.
  - After release, `in_ready`=1.
  - The next transfer (mask 8'b0000_0010) issues only `sel_o`=1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and FSM state encoding for the demux sequencer.
package demux_pkg;
  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
endpackage

// File: rtl/demux_next_ch.sv
// Rotating priority encoder: first set bit of mask at or after start, wrapping mod NCH.
module demux_next_ch
  import demux_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] ch,
  output logic             found
);
  // Scan from the far end so the smallest offset from start wins.
  always_comb begin
    ch    = '0;
    found = |mask;
    for (int i = NCH-1; i >= 0; i--) begin
      if (mask[start + SEL_W'(i)]) ch = start + SEL_W'(i);
    end
  end
endmodule

// File: rtl/demux_seq.sv
// Sequencer driving a 1-to-8 demux: one bit fanned out to each masked channel for DWELL cycles.
// Optional DEMUX_SEQ_RR_EN rotates the starting channel after each non-empty transfer.
module demux_seq
  import demux_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_data,
  input  logic [NCH-1:0]   in_mask,
  output logic [SEL_W-1:0] sel_o,
  output logic             bit_o,
  output logic             en_o,
  output logic             busy,
  output logic             word_done
);
  localparam int DW = $clog2(DWELL + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [DW-1:0] DW_INIT  = DW'(DWELL - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_n;
  logic [NCH-1:0]   pend, pend_n, pend_clr, enc_mask;
  logic [DW-1:0]    dcnt, dcnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [SEL_W-1:0] sel_n, ptr, ch;
  logic             bit_n, en_n, wd_n, found, accept;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign pend_clr = pend & ~(NCH'(1) << sel_o);
  // In IDLE the encoder looks at the incoming mask so the first beat starts on the accept edge.
  assign enc_mask = (state == S_IDLE) ? in_mask : pend_clr;

  demux_next_ch u_next_ch (
    .mask  (enc_mask),
    .start (ptr),
    .ch    (ch),
    .found (found)
  );

`ifdef DEMUX_SEQ_RR_EN
  logic done;
  assign done = (state == S_ISSUE) && (dcnt == '0) && !found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= '0;
    else if (done) ptr <= sel_o + SEL_W'(1);
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_n = state;
    pend_n  = pend;
    dcnt_n  = dcnt;
    gcnt_n  = gcnt;
    sel_n   = sel_o;
    bit_n   = bit_o;
    en_n    = 1'b0;
    wd_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          pend_n = in_mask;
          if (found) begin
            state_n = S_ISSUE;
            sel_n   = ch;
            bit_n   = in_data;
            en_n    = 1'b1;
            dcnt_n  = DW_INIT;
          end else begin
            wd_n    = 1'b1;
            state_n = (GAP > 0) ? S_GAP : S_IDLE;
            gcnt_n  = GAP_INIT;
          end
        end
      end
      S_ISSUE: begin
        en_n = 1'b1;
        if (dcnt != '0) begin
          dcnt_n = dcnt - 1'b1;
        end else begin
          pend_n = pend_clr;
          if (found) begin
            sel_n  = ch;
            dcnt_n = DW_INIT;
          end else begin
            en_n    = 1'b0;
            wd_n    = 1'b1;
            state_n = (GAP > 0) ? S_GAP : S_IDLE;
            gcnt_n  = GAP_INIT;
          end
        end
      end
      S_GAP: begin
        if (gcnt == '0) state_n = S_IDLE;
        else            gcnt_n  = gcnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pend      <= '0;
      dcnt      <= '0;
      gcnt      <= '0;
      sel_o     <= '0;
      bit_o     <= 1'b0;
      en_o      <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      dcnt      <= dcnt_n;
      gcnt      <= gcnt_n;
      sel_o     <= sel_n;
      bit_o     <= bit_n;
      en_o      <= en_n;
      busy      <= (state_n != S_IDLE);
      word_done <= wd_n;
    end
  end
endmodule

// File: tb/tb_demux_seq.sv
// Directed bench for demux_seq with DWELL=2, GAP=1; expectations hand-derived per cycle.
module tb_demux_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;
  logic [7:0] in_mask = 8'h00;
  logic       in_ready, bit_o, en_o, busy, word_done;
  logic [2:0] sel_o;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  demux_seq #(.DWELL(2), .GAP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .sel_o     (sel_o),
    .bit_o     (bit_o),
    .en_o      (en_o),
    .busy      (busy),
    .word_done (word_done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Offer one transfer; returns in cycle 1 of that transfer.
  task automatic start_xfer(input logic d, input logic [7:0] m);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vecs++;
      errs++;
      $display("FAIL start_xfer_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vecs++;
    if ({en_o, sel_o, bit_o, word_done, busy} !== 7'b0) begin
      errs++;
      $display("FAIL reset_hold: got %b required 0000000", {en_o, sel_o, bit_o, word_done, busy});
    end
    rst = 1'b0;
    tick();
    vecs++;
    if ({en_o, sel_o, bit_o, word_done, in_ready, busy} !== 8'b0_000_0_0_1_0) begin
      errs++;
      $display("FAIL reset_release: got %b required 00000010",
               {en_o, sel_o, bit_o, word_done, in_ready, busy});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (en_o !== 1'b0) begin
        errs++;
        $display("FAIL reset_idle_en: cycle %0d en_o=%b required 0", i, en_o);
      end
    end
  endtask

  // Vector layout: {en, sel[2:0], bit, word_done, in_ready, busy}
  task automatic test_basic();
    logic [7:0] exp [6];
    exp = '{8'b1_000_1_0_0_1, 8'b1_000_1_0_0_1, 8'b1_010_1_0_0_1,
            8'b1_010_1_0_0_1, 8'b0_010_1_1_0_1, 8'b0_010_1_0_1_0};
    start_xfer(1'b1, 8'b0000_0101);
    for (int c = 0; c < 6; c++) begin
      vecs++;
      if ({en_o, sel_o, bit_o, word_done, in_ready, busy} !== exp[c]) begin
        errs++;
        $display("FAIL basic_c%0d: got %b required %b", c + 1,
                 {en_o, sel_o, bit_o, word_done, in_ready, busy}, exp[c]);
      end
      tick();
    end
  endtask

  // Runs right after test_basic: sel/bit must hold 2/1 through an empty transfer.
  task automatic test_zero_mask();
    logic [7:0] exp [2];
    exp = '{8'b0_010_1_1_0_1, 8'b0_010_1_0_1_0};
    start_xfer(1'b0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      vecs++;
      if ({en_o, sel_o, bit_o, word_done, in_ready, busy} !== exp[c]) begin
        errs++;
        $display("FAIL zero_mask_c%0d: got %b required %b", c + 1,
                 {en_o, sel_o, bit_o, word_done, in_ready, busy}, exp[c]);
      end
      tick();
    end
  endtask

  task automatic test_full_mask();
    logic [7:0] e;
    logic [2:0] s;
    do_reset();
    start_xfer(1'b0, 8'hFF);
    for (int c = 1; c <= 18; c++) begin
      s = (c <= 16) ? 3'((c - 1) / 2) : 3'd7;
      e = {(c <= 16), s, 1'b0, (c == 17), (c == 18), (c <= 17)};
      vecs++;
      if ({en_o, sel_o, bit_o, word_done, in_ready, busy} !== e) begin
        errs++;
        $display("FAIL full_mask_c%0d: got %b required %b", c,
                 {en_o, sel_o, bit_o, word_done, in_ready, busy}, e);
      end
      tick();
    end
  endtask

  task automatic test_rr();
    logic [3:0] exp1 [4];
    logic [3:0] exp2 [4];
    exp1 = '{4'b1_001, 4'b1_001, 4'b1_010, 4'b1_010};
`ifdef DEMUX_SEQ_RR_EN
    exp2 = '{4'b1_011, 4'b1_011, 4'b1_000, 4'b1_000};
`else
    exp2 = '{4'b1_000, 4'b1_000, 4'b1_011, 4'b1_011};
`endif
    do_reset();
    start_xfer(1'b1, 8'b0000_0110);
    for (int c = 0; c < 4; c++) begin
      vecs++;
      if ({en_o, sel_o} !== exp1[c]) begin
        errs++;
        $display("FAIL rr_first_c%0d: got %b required %b", c + 1, {en_o, sel_o}, exp1[c]);
      end
      tick();
    end
    tick();
    start_xfer(1'b1, 8'b0000_1001);
    for (int c = 0; c < 4; c++) begin
      vecs++;
      if ({en_o, sel_o} !== exp2[c]) begin
        errs++;
        $display("FAIL rr_second_c%0d: got %b required %b", c + 1, {en_o, sel_o}, exp2[c]);
      end
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] masks [3];
    int acc_e [3];
    int wd_e [3];
    int exp_acc [3];
    int exp_wd [3];
    int na = 0;
    int nw = 0;
    logic acc;
    masks   = '{8'h01, 8'h00, 8'h12};
    acc_e   = '{-1, -1, -1};
    wd_e    = '{-1, -1, -1};
    exp_acc = '{0, 4, 6};
    exp_wd  = '{2, 4, 10};
    do_reset();
    in_valid = 1'b1;
    in_data  = 1'b1;
    in_mask  = masks[0];
    for (int k = 0; k < 30; k++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        if (na < 3) acc_e[na] = k;
        na++;
        if (na < 3) in_mask = masks[na];
        else        in_valid = 1'b0;
      end
      if (word_done) begin
        if (nw < 3) wd_e[nw] = k;
        nw++;
      end
    end
    in_valid = 1'b0;
    vecs++;
    if (na !== 3) begin
      errs++;
      $display("FAIL b2b_accepts: got %0d required 3", na);
    end
    vecs++;
    if (nw !== 3) begin
      errs++;
      $display("FAIL b2b_word_done: got %0d required 3", nw);
    end
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (acc_e[i] !== exp_acc[i]) begin
        errs++;
        $display("FAIL b2b_accept_edge%0d: got %0d required %0d", i, acc_e[i], exp_acc[i]);
      end
      vecs++;
      if (wd_e[i] !== exp_wd[i]) begin
        errs++;
        $display("FAIL b2b_done_edge%0d: got %0d required %0d", i, wd_e[i], exp_wd[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int ne = 0;
    int bad = 0;
    int nwd = 0;
    do_reset();
    start_xfer(1'b1, 8'b0000_0101);
    tick();
    tick();
    vecs++;
    if ({en_o, sel_o} !== 4'b1_010) begin
      errs++;
      $display("FAIL mid_reset_pre: got %b required 1010", {en_o, sel_o});
    end
    rst = 1'b1;
    #1;
    vecs++;
    if ({en_o, busy, sel_o, bit_o} !== 6'b0) begin
      errs++;
      $display("FAIL mid_reset_async: got %b required 000000", {en_o, busy, sel_o, bit_o});
    end
    repeat (2) tick();
    rst = 1'b0;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset_ready: got %b required 1", in_ready);
    end
    start_xfer(1'b1, 8'b0000_0010);
    for (int c = 0; c < 6; c++) begin
      if (en_o) begin
        ne++;
        if (sel_o !== 3'd1) bad++;
      end
      if (word_done) nwd++;
      tick();
    end
    vecs++;
    if (ne !== 2) begin
      errs++;
      $display("FAIL mid_reset_en_cycles: got %0d required 2", ne);
    end
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL mid_reset_sel: %0d beats off channel 1, required 0", bad);
    end
    vecs++;
    if (nwd !== 1) begin
      errs++;
      $display("FAIL mid_reset_done: got %0d required 1", nwd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_mask();
    test_full_mask();
    test_rr();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
